regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file for the CPU core, generalising the single-write, dual-read register file. It adds configurable read/write port counts, a dedicated PC register with a read offset, write-to-read bypass, and deterministic write-port priority. A post-reset clearing sweep zeroes every general register and holds `ready` low until the sweep finishes. The block sits between decode (read ports), writeback (write ports) and fetch (`pc`/`new_pc`).

## Interface
Parameters:
- `WIDTH`, 32: data width in bits.
- `COUNT`, 16: architectural registers, including the PC.
- `NREAD`, 2: number of read ports.
- `NWRITE`, 2: number of write ports.
- `PC_INDEX`, 15: address mapped to the PC.
- `PC_READ_OFFSET`, 8: value added to the PC on a PC read.
- `AW`: $clog2(COUNT), derived, not overridable.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `nreset`  in  1  reset, synchronous, active-high; while 1, all state resets.
- `ready`  out  1  high once the clearing sweep has completed.
- `rd_addr`  in  NREAD×AW  read addresses, sampled at the clock edge.
- `rd_data`  out  NREAD×WIDTH  registered read data.
- `wr_en`  in  NWRITE  per-port write enables.
- `wr_addr`  in  NWRITE×AW  write addresses.
- `wr_data`  in  NWRITE×WIDTH  write data.
- `new_pc`  in  WIDTH  next PC from fetch.
- `pc`  out  WIDTH  current PC.

## Operation
- Storage holds COUNT-1 general registers. The PC is a separate register, not in the array.
- **FSM, two states.**
  - SWEEP: entered on reset. A counter `clr_idx` goes 0..COUNT-2 and writes 0 to one entry per cycle. When `clr_idx` reaches COUNT-2, the FSM moves to READY on the next edge.
  - READY: terminal state. `ready`=1.
- **During SWEEP:**
  - All `wr_en` are ignored.
  - `pc` holds 0 and `new_pc` is ignored.
  - `rd_data` drives 0.
- **Writes (READY only):**
  - Each enabled port with `wr_addr` ≠ PC_INDEX writes its entry at the edge.
  - If several ports target the same address, the highest port index wins.
- **PC update:**
  - If any enabled port targets PC_INDEX, `pc` takes that port's data (highest index wins).
  - Otherwise `pc` takes `new_pc`.
- **Reads (READY only):**
  - For addr ≠ PC_INDEX, `rd_data[i]` gets the entry value after this edge's writes are applied (write-first bypass; priority as above).
  - For addr = PC_INDEX, `rd_data[i]` gets (next `pc`) + PC_READ_OFFSET, truncated to WIDTH (wraps modulo 2^WIDTH).
- **Out of range:** addresses ≥ COUNT read 0, and writes to them are dropped.

## Timing
- Reset values: `pc`=0, every `rd_data`=0, `ready`=0, `clr_idx`=0, state=SWEEP. Array contents are undefined until the sweep overwrites them.
- Sweep length: COUNT-1 cycles after `nreset` falls.
  - With COUNT=16, `ready` rises at the 15th edge after release.
  - The first write is accepted in the cycle `ready`=1.
- Reasserting `nreset` mid-sweep or in READY restarts the sweep from index 0. Entries already cleared are cleared again.
- Read latency is 1 cycle: the address presented in cycle t returns data in t+1, including same-edge writes.
- PC latency is 1 cycle: `new_pc` or a PC write in cycle t is visible on `pc` in t+1.

## Structure
- Package `regfile_pkg` holds:
  - the FSM enum type `rf_state_t` (SWEEP, READY);
  - a function `rf_aw(count)` returning the address width;
  - the default constants WIDTH, COUNT, PC_INDEX and PC_READ_OFFSET, shared with decode and fetch.
- Sub-module `regfile_clear_seq` owns the FSM and `clr_idx`. Its outputs are `clr_we`, `clr_addr` and `ready`.
- The top level contains:
  - the array;
  - the per-port priority merge, as a generate loop over NWRITE;
  - the bypass and read muxes, as a generate loop over NREAD;
  - the PC register.

## Test plan
- Reset, then release with COUNT=16 → `ready` stays 0 for 14 edges and is 1 at edge 15. Reads of r0..r14 return 0 and `pc`=0.
- In READY, port0 writes r3=0xAAAA and port1 writes r3=0x5555 in the same cycle, with rd_addr0=3 that cycle → `rd_data0`=0x5555 next cycle and thereafter.
- `new_pc`=0x100 with no PC write → `pc`=0x100 next cycle. A read of r15 in the same cycle returns 0x108. With `pc` near 0xFFFFFFFC, a PC read returns a value that wraps to 0x4.
- Port1 writes r15=0x2000 while `new_pc`=0x104 → `pc`=0x2000 next cycle. r15 is not written in the array.
- `nreset` pulsed at sweep cycle 7 → `ready` rises 15 edges after the second release. A write attempted during the sweep has no effect, and the read returns 0.
- Write with `wr_addr`=15 and `wr_en`=0 → `pc` follows `new_pc` and the array is unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file, also used by decode and fetch.
package regfile_pkg;

  // Clearing-sweep FSM states.
  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } rf_state_t;

  localparam int RF_WIDTH          = 32;
  localparam int RF_COUNT          = 16;
  localparam int RF_PC_INDEX       = 15;
  localparam int RF_PC_READ_OFFSET = 8;

  // Address width for a register file of 'count' entries (never below 1 bit).
  function automatic int rf_aw(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clearing sweep: walks every general register once, writing zero,
// then parks in READY until the next reset.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int COUNT = RF_COUNT,
  parameter int AW    = rf_aw(RF_COUNT)
) (
  input  logic          clk,
  input  logic          nreset,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          ready_q;

  // State, sweep index and ready flag; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q   <= SWEEP;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= (state_d == READY);
    end
  end

  // Next state: one entry cleared per cycle, leave SWEEP after the last array entry.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      SWEEP: begin
        clr_we = 1'b1;
        if (clr_idx_q == AW'(COUNT - 2)) begin
          state_d = READY;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1'b1);
        end
      end
      READY: begin
        clr_we = 1'b0;
      end
      default: begin
        state_d   = SWEEP;
        clr_idx_d = '0;
      end
    endcase
  end

  assign clr_addr = clr_idx_q;
  assign ready    = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with separate PC register, write-first read bypass
// and highest-port-wins write priority.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH          = RF_WIDTH,
  parameter int COUNT          = RF_COUNT,
  parameter int NREAD          = 2,
  parameter int NWRITE         = 2,
  parameter int PC_INDEX       = RF_PC_INDEX,
  parameter int PC_READ_OFFSET = RF_PC_READ_OFFSET
) (
  input  logic                                  clk,
  input  logic                                  nreset,
  output logic                                  ready,
  input  logic [NREAD-1:0][rf_aw(COUNT)-1:0]    rd_addr,
  output logic [NREAD-1:0][WIDTH-1:0]           rd_data,
  input  logic [NWRITE-1:0]                     wr_en,
  input  logic [NWRITE-1:0][rf_aw(COUNT)-1:0]   wr_addr,
  input  logic [NWRITE-1:0][WIDTH-1:0]          wr_data,
  input  logic [WIDTH-1:0]                      new_pc,
  output logic [WIDTH-1:0]                      pc
);

  localparam int AW   = rf_aw(COUNT);
  localparam int NGEN = COUNT - 1;

  // Array slot for an architectural address: addresses above the PC shift down
  // by one so the PC leaves no hole in the array.
  function automatic logic [AW-1:0] to_idx(input logic [AW-1:0] a);
    return (int'(a) > PC_INDEX) ? a - AW'(1'b1) : a;
  endfunction

  logic              clr_we_s;
  logic [AW-1:0]     clr_addr_s;
  logic [WIDTH-1:0]  mem_q [NGEN];
  logic [WIDTH-1:0]  mem_d [NGEN];
  logic [WIDTH-1:0]  pc_q, pc_d;

  logic [NWRITE-1:0]         wr_ok_s;
  logic [NWRITE-1:0]         wr_pc_s;
  logic [NWRITE-1:0][AW-1:0] wr_idx_s;

  regfile_clear_seq #(
    .COUNT (COUNT),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .nreset   (nreset),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s),
    .ready    (ready)
  );

  // Per-port write decode: array write, PC write, or dropped (sweep / out of range).
  for (genvar p = 0; p < NWRITE; p++) begin : g_wr
    assign wr_ok_s[p]  = ready & wr_en[p] & (int'(wr_addr[p]) < COUNT)
                         & (int'(wr_addr[p]) != PC_INDEX);
    assign wr_pc_s[p]  = ready & wr_en[p] & (int'(wr_addr[p]) == PC_INDEX);
    assign wr_idx_s[p] = to_idx(wr_addr[p]);
  end

  // Array next state: sweep clear, then port writes in ascending order so the highest port wins.
  always_comb begin
    mem_d = mem_q;
    if (clr_we_s) begin
      mem_d[clr_addr_s] = '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_ok_s[p]) begin
          mem_d[wr_idx_s[p]] = wr_data[p];
        end else begin
          mem_d[wr_idx_s[p]] = mem_d[wr_idx_s[p]];
        end
      end
    end
  end

  // PC next state: held at zero during the sweep, otherwise highest-port PC write beats new_pc.
  always_comb begin
    pc_d = new_pc;
    if (!ready) begin
      pc_d = '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_pc_s[p]) begin
          pc_d = wr_data[p];
        end else begin
          pc_d = pc_d;
        end
      end
    end
  end

  // Array storage; contents are defined only once the sweep has run.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (nreset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

  // Read ports: registered, returning post-write values (write-first bypass).
  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic [WIDTH-1:0] rd_d, rd_q;

    // Read mux: zero in sweep, offset PC, bypassed array entry, or zero when out of range.
    always_comb begin
      rd_d = '0;
      if (!ready) begin
        rd_d = '0;
      end else if (int'(rd_addr[r]) == PC_INDEX) begin
        rd_d = pc_d + WIDTH'(PC_READ_OFFSET);
      end else if (int'(rd_addr[r]) < COUNT) begin
        rd_d = mem_d[to_idx(rd_addr[r])];
      end else begin
        rd_d = '0;
      end
    end

    // Read data register.
    always_ff @(posedge clk) begin
      if (nreset) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign rd_data[r] = rd_q;
  end

endmodule
